// File: rtl/uart_pkg.sv
// Shared packet constants, decoder FSM states and the check-byte helper.
// Build with UART_CHECKSUM_EN defined to add the trailing XOR check byte.
package uart_pkg;

   localparam logic [7:0] HDR_BYTE = 8'hA5;

`ifdef UART_CHECKSUM_EN
   localparam int PKT_DATA_BYTES = 5;
`else
   localparam int PKT_DATA_BYTES = 4;
`endif

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_B1,
      ST_B2,
      ST_B3,
      ST_B4
`ifdef UART_CHECKSUM_EN
      , ST_CHK
`endif
   } state_t;

   function automatic logic [7:0] chk_byte(input logic [7:0] b1, input logic [7:0] b2,
                                           input logic [7:0] b3, input logic [7:0] b4);
      return b1 ^ b2 ^ b3 ^ b4;
   endfunction

endpackage

// File: rtl/uart_char_decoder_if.sv
// Byte stream in, committed remote-character position and status strobes out.
// No backpressure: the decoder takes every rx_valid strobe.
interface uart_char_decoder_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        vsync;
   logic [11:0] x_value;
   logic [11:0] y_value;
   logic [1:0]  level_remote;
   logic        pkt_ok;
   logic        pkt_err;
   logic        link_alive;

   modport master (
      output rx_data, rx_valid, vsync,
      input  x_value, y_value, level_remote, pkt_ok, pkt_err, link_alive
   );

   modport slave (
      input  rx_data, rx_valid, vsync,
      output x_value, y_value, level_remote, pkt_ok, pkt_err, link_alive
   );
endinterface

// File: rtl/uart_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last restart; expired flags the
// CYCLES-th quiet cycle combinationally, and a restart in that same cycle suppresses it.
module uart_timeout #(
   parameter int CYCLES = 65000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_restart,
   input  logic i_enable,
   output logic o_expired
);

   localparam int CNT_W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

   logic [CNT_W-1:0] r_count;

   assign o_expired = i_enable && !i_restart && (r_count == LAST);

   always_ff @(posedge clk) begin
      if (rst || i_restart || !i_enable) begin
         r_count <= '0;
      end else if (r_count != LAST) begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/uart_char_decoder.sv
// Decodes A5-framed position packets into shadow regs, committed the cycle after a vsync rise;
// pkt_ok/pkt_err strobe one cycle after the deciding byte. No backpressure. Option: UART_CHECKSUM_EN.
module uart_char_decoder
   import uart_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 65000,
   parameter int LINK_FRAMES    = 60
) (
   input  logic              clk,
   input  logic              rst,
   uart_char_decoder_if.slave bus
);

   localparam int FR_W = $clog2(LINK_FRAMES + 1);

   state_t          r_state;
   state_t          w_next_state;
   logic [7:0]      r_stage [PKT_DATA_BYTES-1];
   logic [11:0]     r_sh_x, r_sh_y, r_x, r_y;
   logic [1:0]      r_sh_lvl, r_lvl;
   logic            r_pending, r_pkt_ok, r_pkt_err, r_link_alive, r_vsync_d;
   logic [FR_W-1:0] r_frames;

   logic            w_done, w_chk_bad, w_expired, w_busy, w_vs_rise;
   logic [11:0]     w_new_x, w_new_y;
   logic [1:0]      w_new_lvl;

   assign w_busy    = (r_state != ST_IDLE);
   assign w_vs_rise = bus.vsync && !r_vsync_d;

   uart_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk       (clk),
      .rst       (rst),
      .i_restart (bus.rx_valid),
      .i_enable  (w_busy),
      .o_expired (w_expired)
   );

   assign w_new_x = {r_stage[0][7:4], r_stage[1]};
   assign w_new_y = {r_stage[0][3:0], r_stage[2]};
`ifdef UART_CHECKSUM_EN
   assign w_new_lvl = r_stage[3][1:0];
`else
   assign w_new_lvl = bus.rx_data[1:0];
`endif

   always_comb begin
      w_next_state = r_state;
      w_done       = 1'b0;
      w_chk_bad    = 1'b0;
      if (w_expired) begin
         w_next_state = ST_IDLE;
      end else if (bus.rx_valid) begin
         case (r_state)
            ST_IDLE: if (bus.rx_data == HDR_BYTE) w_next_state = ST_B1;
            ST_B1:   w_next_state = ST_B2;
            ST_B2:   w_next_state = ST_B3;
            ST_B3:   w_next_state = ST_B4;
`ifdef UART_CHECKSUM_EN
            ST_B4:   w_next_state = ST_CHK;
            ST_CHK: begin
               w_next_state = ST_IDLE;
               if (bus.rx_data == chk_byte(r_stage[0], r_stage[1], r_stage[2], r_stage[3]))
                  w_done = 1'b1;
               else
                  w_chk_bad = 1'b1;
            end
`else
            ST_B4: begin
               w_next_state = ST_IDLE;
               w_done       = 1'b1;
            end
`endif
            default: w_next_state = ST_IDLE;
         endcase
      end
   end

   // Staging keeps a half-received packet away from the shadow of a still-pending one.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < PKT_DATA_BYTES - 1; i++) r_stage[i] <= '0;
      end else if (bus.rx_valid) begin
         case (r_state)
            ST_B1: r_stage[0] <= bus.rx_data;
            ST_B2: r_stage[1] <= bus.rx_data;
            ST_B3: r_stage[2] <= bus.rx_data;
`ifdef UART_CHECKSUM_EN
            ST_B4: r_stage[3] <= bus.rx_data;
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_vsync_d    <= 1'b0;
         r_sh_x       <= '0;
         r_sh_y       <= '0;
         r_sh_lvl     <= '0;
         r_pending    <= 1'b0;
         r_x          <= '0;
         r_y          <= '0;
         r_lvl        <= '0;
         r_pkt_ok     <= 1'b0;
         r_pkt_err    <= 1'b0;
         r_link_alive <= 1'b0;
         r_frames     <= '0;
      end else begin
         r_state   <= w_next_state;
         r_vsync_d <= bus.vsync;
         r_pkt_ok  <= w_done;
         r_pkt_err <= w_expired || w_chk_bad;

         // A packet finishing on the vsync edge lands in shadow after the old one commits.
         if (w_vs_rise && r_pending) begin
            r_x   <= r_sh_x;
            r_y   <= r_sh_y;
            r_lvl <= r_sh_lvl;
         end
         if (w_done) begin
            r_sh_x    <= w_new_x;
            r_sh_y    <= w_new_y;
            r_sh_lvl  <= w_new_lvl;
            r_pending <= 1'b1;
         end else if (w_vs_rise) begin
            r_pending <= 1'b0;
         end

         if (w_done) begin
            r_frames     <= '0;
            r_link_alive <= 1'b1;
         end else if (w_vs_rise && (r_frames != FR_W'(LINK_FRAMES))) begin
            r_frames <= r_frames + 1'b1;
            if (r_frames == FR_W'(LINK_FRAMES - 1)) r_link_alive <= 1'b0;
         end
      end
   end

   assign bus.x_value      = r_x;
   assign bus.y_value      = r_y;
   assign bus.level_remote = r_lvl;
   assign bus.pkt_ok       = r_pkt_ok;
   assign bus.pkt_err      = r_pkt_err;
   assign bus.link_alive   = r_link_alive;

endmodule

// File: tb/tb_uart_char_decoder.sv
// Scoreboard bench for uart_char_decoder: a packet-level reference model queues the expected
// outputs for every cycle and a negedge monitor pops and compares. Honours UART_CHECKSUM_EN.
module tb_uart_char_decoder;

   localparam int T    = 50;
   localparam int LINK = 60;
`ifdef UART_CHECKSUM_EN
   localparam int NDATA = 5;
`else
   localparam int NDATA = 4;
`endif

   typedef struct {
      logic        ok;
      logic        err;
      logic        alive;
      logic [11:0] x;
      logic [11:0] y;
      logic [1:0]  lvl;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   uart_char_decoder_if bus();

   uart_char_decoder #(.TIMEOUT_CYCLES(T), .LINK_FRAMES(LINK)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int    vectors     = 0;
   int    miscompares = 0;
   string phase       = "reset";
   exp_t  exp_q[$];
   exp_t  mon_e;

   // Reference model state, kept at packet level.
   logic        m_in_pkt;
   logic [7:0]  m_buf[$];
   int          m_gap;
   logic [11:0] m_sh_x, m_sh_y, m_x, m_y;
   logic [1:0]  m_sh_lvl, m_lvl;
   logic        m_pend, m_alive, m_prev_vs;
   int          m_frames;
   int          vcnt = 0;

   function automatic logic [7:0] xor4(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] d);
      return a ^ b ^ c ^ d;
   endfunction

   task automatic tick(input logic v, input logic [7:0] d, input logic vs, input logic r);
      exp_t e;
      logic ok, err, good;
      rst = r; bus.rx_valid = v; bus.rx_data = d; bus.vsync = vs;
      @(posedge clk);
      ok = 1'b0; err = 1'b0;
      if (r) begin
         m_in_pkt = 0; m_buf.delete(); m_gap = 0;
         m_sh_x = 0; m_sh_y = 0; m_sh_lvl = 0; m_x = 0; m_y = 0; m_lvl = 0;
         m_pend = 0; m_alive = 0; m_prev_vs = 0; m_frames = 0;
      end else begin
         if (v) begin
            m_gap = 0;
            if (!m_in_pkt) begin
               if (d == 8'hA5) begin
                  m_in_pkt = 1;
                  m_buf.delete();
               end
            end else begin
               m_buf.push_back(d);
               if (m_buf.size() == NDATA) begin
                  m_in_pkt = 0;
                  good = 1'b1;
`ifdef UART_CHECKSUM_EN
                  good = (m_buf[4] == xor4(m_buf[0], m_buf[1], m_buf[2], m_buf[3]));
`endif
                  if (good) ok = 1'b1; else err = 1'b1;
               end
            end
         end else if (m_in_pkt) begin
            m_gap++;
            if (m_gap == T) begin
               m_in_pkt = 0;
               err = 1'b1;
            end
         end
         if (vs && !m_prev_vs) begin
            if (m_pend) begin
               m_x = m_sh_x; m_y = m_sh_y; m_lvl = m_sh_lvl;
               m_pend = 0;
            end
            if (m_frames < LINK) m_frames++;
            if (m_frames == LINK) m_alive = 0;
         end
         if (ok) begin
            m_sh_x   = {m_buf[0][7:4], m_buf[1]};
            m_sh_y   = {m_buf[0][3:0], m_buf[2]};
            m_sh_lvl = m_buf[3][1:0];
            m_pend   = 1; m_frames = 0; m_alive = 1;
         end
         m_prev_vs = vs;
      end
      e.ok = ok; e.err = err; e.alive = m_alive; e.x = m_x; e.y = m_y; e.lvl = m_lvl;
      exp_q.push_back(e);
      #1;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         vectors++;
         if (bus.pkt_ok !== mon_e.ok || bus.pkt_err !== mon_e.err ||
             bus.link_alive !== mon_e.alive || bus.x_value !== mon_e.x ||
             bus.y_value !== mon_e.y || bus.level_remote !== mon_e.lvl) begin
            miscompares++;
            $display("FAIL %s @%0t: got ok=%b err=%b alive=%b x=%h y=%h lvl=%0d, want ok=%b err=%b alive=%b x=%h y=%h lvl=%0d",
                     phase, $time, bus.pkt_ok, bus.pkt_err, bus.link_alive, bus.x_value,
                     bus.y_value, bus.level_remote, mon_e.ok, mon_e.err, mon_e.alive,
                     mon_e.x, mon_e.y, mon_e.lvl);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic send(input logic [7:0] b, input logic vs);
      tick(1'b1, b, vs, 1'b0);
      tick(1'b0, 8'h00, vs, 1'b0);
   endtask

   task automatic vs_pulse();
      tick(1'b0, 8'h00, 1'b1, 1'b0);
      tick(1'b0, 8'h00, 1'b1, 1'b0);
      idle(2);
   endtask

   task automatic send_pkt(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                           input logic [7:0] b4, input logic [7:0] bad, input logic last_vs);
      send(8'hA5, 1'b0);
      send(b1, 1'b0);
      send(b2, 1'b0);
      send(b3, 1'b0);
`ifdef UART_CHECKSUM_EN
      send(b4, 1'b0);
      send(xor4(b1, b2, b3, b4) ^ bad, last_vs);
`else
      if (bad != 8'h00) send(b4, last_vs); else send(b4, last_vs);
`endif
   endtask

   // Random-phase cycle: vsync runs free with a 19-cycle period.
   task automatic rtick(input logic v, input logic [7:0] d);
      tick(v, d, (vcnt % 19) < 3, 1'b0);
      vcnt++;
   endtask

   task automatic rbyte(input logic [7:0] b);
      int g;
      g = ($urandom_range(0, 11) == 0) ? (T - 1 + $urandom_range(0, 2)) : $urandom_range(0, 3);
      repeat (g) rtick(1'b0, 8'h00);
      if ($urandom_range(0, 80) == 0) tick(1'b0, 8'h00, 1'b0, 1'b1);
      rtick(1'b1, b);
   endtask

   initial begin
      logic [7:0] r1, r2, r3, r4, bad;
      bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.vsync = 1'b0;
      @(posedge clk); #1;
      tick(1'b0, 8'h00, 1'b0, 1'b1);
      tick(1'b0, 8'h00, 1'b0, 1'b1);

      phase = "basic_packet";
      idle(2);
      send_pkt(8'h12, 8'h34, 8'h56, 8'h02, 8'h00, 1'b0);
      idle(3);
      vs_pulse();
      idle(2);

      phase = "garbage_then_packet";
      tick(1'b0, 8'h00, 1'b0, 1'b1);
      send(8'h00, 1'b0); send(8'hFF, 1'b0); send(8'h11, 1'b0);
      send_pkt(8'h12, 8'h34, 8'h56, 8'h02, 8'h00, 1'b0);
      vs_pulse();

      phase = "timeout";
      send(8'hA5, 1'b0); send(8'h12, 1'b0); send(8'h34, 1'b0);
      idle(T + 5);
      send_pkt(8'hAB, 8'hCD, 8'hEF, 8'h01, 8'h00, 1'b0);
      vs_pulse();

`ifdef UART_CHECKSUM_EN
      phase = "bad_checksum";
      send_pkt(8'h12, 8'h34, 8'h56, 8'h02, 8'h01, 1'b0);
      vs_pulse();
      vs_pulse();
`endif

      phase = "done_on_vsync_edge";
      send_pkt(8'h21, 8'h43, 8'h65, 8'h03, 8'h00, 1'b1);
      idle(3);
      vs_pulse();

      phase = "link_loss";
      send_pkt(8'h5A, 8'h77, 8'h88, 8'h01, 8'h00, 1'b0);
      repeat (LINK + 2) vs_pulse();

      phase = "reset_mid_packet";
      send(8'hA5, 1'b0); send(8'h12, 1'b0);
      tick(1'b0, 8'h00, 1'b0, 1'b1);
      idle(T + 5);

      phase = "random";
      for (int p = 0; p < 40; p++) begin
         repeat ($urandom_range(0, 2)) rbyte(8'($urandom_range(0, 255)));
         r1 = 8'($urandom_range(0, 255)); r2 = 8'($urandom_range(0, 255));
         r3 = 8'($urandom_range(0, 255)); r4 = 8'($urandom_range(0, 255));
         bad = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
         rbyte(8'hA5); rbyte(r1); rbyte(r2); rbyte(r3); rbyte(r4);
`ifdef UART_CHECKSUM_EN
         rbyte(xor4(r1, r2, r3, r4) ^ bad);
`else
         if (bad != 8'h00) rtick(1'b0, 8'h00);
`endif
      end
      repeat (40) rtick(1'b0, 8'h00);
      idle(2);

      @(negedge clk);
      @(posedge clk);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected cycles left unchecked, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
